serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow flip-flop.
- Serial counterpart to the datapath's combinational full-adder cell: the inverse arithmetic direction, with the carry chain unrolled in time.
- Sits behind a start/done handshake so a controller can issue operations and collect diff, borrow and zero flags.

---
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one full-subtractor cell
// plus a borrow flip-flop, wrapped in a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sa, sa_d, sb, sb_d, sr, sr_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             borrow_ff, borrow_ff_d;
    logic             busy_d, done_d, borrow_d, zero_d;
    logic [WIDTH-1:0] diff_d;

    // Full-subtractor cell on the current LSBs
    logic             d_c, bnext_c;
    logic [WIDTH-1:0] res_c;

    assign d_c     = sa[0] ^ sb[0] ^ borrow_ff;
    assign bnext_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow_ff);
    assign res_c   = {d_c, sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sr        <= '0;
            cnt       <= '0;
            borrow_ff <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state     <= state_d;
            sa        <= sa_d;
            sb        <= sb_d;
            sr        <= sr_d;
            cnt       <= cnt_d;
            borrow_ff <= borrow_ff_d;
            busy      <= busy_d;
            done      <= done_d;
            diff      <= diff_d;
            borrow    <= borrow_d;
            zero      <= zero_d;
        end
    end

    always_comb begin
        state_d     = state;
        sa_d        = sa;
        sb_d        = sb;
        sr_d        = sr;
        cnt_d       = cnt;
        borrow_ff_d = borrow_ff;
        busy_d      = busy;
        done_d      = 1'b0;
        diff_d      = diff;
        borrow_d    = borrow;
        zero_d      = zero;

        case (state)
            IDLE: begin
                if (start) begin
                    sa_d        = a;
                    sb_d        = b;
                    borrow_ff_d = 1'b0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                sa_d        = {1'b0, sa[WIDTH-1:1]};
                sb_d        = {1'b0, sb[WIDTH-1:1]};
                sr_d        = res_c;
                borrow_ff_d = bnext_c;
                cnt_d       = cnt + CW'(1);
                // Last bit: publish result and return to IDLE
                if (cnt == LAST) begin
                    diff_d   = res_c;
                    borrow_d = bnext_c;
                    zero_d   = (res_c == '0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, borrow, zero;
    logic [WIDTH-1:0] diff;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge; returns #1 after the accepting edge
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; cyc = edges seen
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 20);
    endtask

    task automatic op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [WIDTH-1:0] ed, input logic eb, input logic ez);
        int cyc;
        issue(av, bv);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, ".lat"}, 32'(cyc), 32'(WIDTH));
        check({tag, ".diff"}, 32'(diff), 32'(ed));
        check({tag, ".borrow"}, 32'(borrow), 32'(eb));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;

        // Reset state
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.diff", 32'(diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        op("t2a", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        op("t2b", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op("t3a", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1);
        op("t3b", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

        // Start during RUN is ignored
        issue(8'h10, 8'h01);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        start = 1'b1;
        a     = 8'h00;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t4.no_early_done", 32'(done), 32'd0);
        wait_done(cyc);
        check("t4.lat", 32'(cyc + 3), 32'(WIDTH));
        check("t4.diff", 32'(diff), 32'h0F);
        check("t4.borrow", 32'(borrow), 32'd0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("t4.no_extra_op", 32'(pulses), 32'd0);

        // Back-to-back: start held in the done cycle
        issue(8'h80, 8'h01);
        wait_done(cyc);
        check("t5a.lat", 32'(cyc), 32'(WIDTH));
        check("t5a.diff", 32'(diff), 32'h7F);
        check("t5a.borrow", 32'(borrow), 32'd0);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5b.busy", 32'(busy), 32'd1);
        check("t5b.done_clr", 32'(done), 32'd0);
        wait_done(cyc);
        check("t5b.lat", 32'(cyc), 32'(WIDTH));
        check("t5b.diff", 32'(diff), 32'hFF);
        check("t5b.borrow", 32'(borrow), 32'd1);
        check("t5b.zero", 32'(zero), 32'd0);

        // Asynchronous reset mid-RUN
        issue(8'h33, 8'h11);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.done", 32'(done), 32'd0);
        check("t6.diff", 32'(diff), 32'd0);
        check("t6.borrow", 32'(borrow), 32'd0);
        check("t6.zero", 32'(zero), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("t6.no_done", 32'(pulses), 32'd0);
        op("t6post", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
